// File: rtl/pipe_mon_pkg.sv
// Shared types and the saturating-increment helper for the pipeline-boundary monitor.
package pipe_mon_pkg;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_HOLD  = 2'd1,
    ERR_MAP   = 2'd2,
    ERR_FLUSH = 2'd3
  } err_kind_e;

  typedef enum logic [1:0] {
    WARM  = 2'd0,
    ARMED = 2'd1,
    FAULT = 2'd2
  } mon_state_e;

  // Counters up to 32 bits wide are widened to 32 bits by the caller.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val == max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_mon_boundary.sv
// One monitored pipeline register: snapshots, priority compare, error pulses, violation count.
// PIPE_MON_ASSERT_EN adds concurrent assertions and cover points for this boundary.
module pipe_mon_boundary
  import pipe_mon_pkg::*;
#(
  parameter int                  BUNDLE_W = 64,
  parameter int                  CNT_W    = 16,
  parameter logic [BUNDLE_W-1:0] BUBBLE   = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [BUNDLE_W-1:0] i_in,
  input  logic [BUNDLE_W-1:0] i_out,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic                i_check,
  input  logic                i_clr,
  output err_kind_e           o_kind,
  output logic                o_err_hold,
  output logic                o_err_map,
  output logic                o_err_flush,
  output logic [CNT_W-1:0]    o_viol_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [BUNDLE_W-1:0] r_in_p;
  logic [BUNDLE_W-1:0] r_out_p;
  logic                r_stall_p;
  logic                r_flush_p;
  logic                r_err_hold;
  logic                r_err_map;
  logic                r_err_flush;
  logic [CNT_W-1:0]    r_cnt;
  err_kind_e           w_kind;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_p    <= '0;
      r_out_p   <= '0;
      r_stall_p <= 1'b0;
      r_flush_p <= 1'b0;
    end else begin
      r_in_p    <= i_in;
      r_out_p   <= i_out;
      r_stall_p <= i_stall;
      r_flush_p <= i_flush;
    end
  end

  // Flush outranks stall, stall outranks a normal update.
  always_comb begin
    w_kind = ERR_NONE;
    if (i_check) begin
      if (r_flush_p) begin
        if (i_out != BUBBLE) w_kind = ERR_FLUSH;
      end else if (r_stall_p) begin
        if (i_out != r_out_p) w_kind = ERR_HOLD;
      end else if (i_out != r_in_p) begin
        w_kind = ERR_MAP;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || i_clr) begin
      r_err_hold  <= 1'b0;
      r_err_map   <= 1'b0;
      r_err_flush <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_err_hold  <= (w_kind == ERR_HOLD);
      r_err_map   <= (w_kind == ERR_MAP);
      r_err_flush <= (w_kind == ERR_FLUSH);
      if (w_kind != ERR_NONE) r_cnt <= CNT_W'(sat_inc(32'(r_cnt), 32'(CNT_MAX)));
    end
  end

  assign o_kind      = w_kind;
  assign o_err_hold  = r_err_hold;
  assign o_err_map   = r_err_map;
  assign o_err_flush = r_err_flush;
  assign o_viol_cnt  = r_cnt;

`ifdef PIPE_MON_ASSERT_EN
  ASSERT_HOLD: assert property (@(posedge clock) disable iff (reset || !i_check)
    (!r_flush_p && r_stall_p) |-> (i_out == r_out_p));
  ASSERT_MAP: assert property (@(posedge clock) disable iff (reset || !i_check)
    (!r_flush_p && !r_stall_p) |-> (i_out == r_in_p));
  ASSERT_FLUSH: assert property (@(posedge clock) disable iff (reset || !i_check)
    r_flush_p |-> (i_out == BUBBLE));
  COVER_STALL: cover property (@(posedge clock) disable iff (reset || !i_check)
    !r_flush_p && r_stall_p);
  COVER_FLUSH: cover property (@(posedge clock) disable iff (reset || !i_check) r_flush_p);
  COVER_UPDATE: cover property (@(posedge clock) disable iff (reset || !i_check)
    !r_flush_p && !r_stall_p);
`else
  // Flag and counter logic only.
`endif

endmodule

// File: rtl/pipe_stage_monitor.sv
// Pipeline-boundary checker: per-boundary monitors, WARM/ARMED/FAULT state, cycle counter
// and lowest-index first-fault record. PIPE_MON_ASSERT_EN enables per-boundary assertions.
module pipe_stage_monitor
  import pipe_mon_pkg::*;
#(
  parameter int                  NUM_STAGES = 4,
  parameter int                  BUNDLE_W   = 64,
  parameter int                  CNT_W      = 16,
  parameter logic [BUNDLE_W-1:0] BUBBLE     = '0,
  localparam int                 SW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_STAGES*BUNDLE_W-1:0] stage_in,
  input  logic [NUM_STAGES*BUNDLE_W-1:0] stage_out,
  input  logic [NUM_STAGES-1:0]        stall,
  input  logic [NUM_STAGES-1:0]        flush,
  input  logic [NUM_STAGES-1:0]        chk_en,
  input  logic                         clr,
  output logic [NUM_STAGES-1:0]        err_hold,
  output logic [NUM_STAGES-1:0]        err_map,
  output logic [NUM_STAGES-1:0]        err_flush,
  output logic                         fault,
  output logic [SW-1:0]                first_stage,
  output logic [1:0]                   first_kind,
  output logic [CNT_W-1:0]             first_cycle,
  output logic [NUM_STAGES*CNT_W-1:0]  viol_cnt
);

  mon_state_e       r_state;
  mon_state_e       w_state_next;
  logic [CNT_W-1:0] r_cycle;
  logic [SW-1:0]    r_first_stage;
  err_kind_e        r_first_kind;
  logic [CNT_W-1:0] r_first_cycle;
  err_kind_e        w_kind [NUM_STAGES];
  logic             w_check_on;
  logic             w_any;
  logic [SW-1:0]    w_idx;
  err_kind_e        w_idx_kind;

  assign w_check_on = (r_state != WARM);

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_bnd
      pipe_mon_boundary #(
        .BUNDLE_W (BUNDLE_W),
        .CNT_W    (CNT_W),
        .BUBBLE   (BUBBLE)
      ) u_bnd (
        .clock       (clock),
        .reset       (reset),
        .i_in        (stage_in[gi*BUNDLE_W +: BUNDLE_W]),
        .i_out       (stage_out[gi*BUNDLE_W +: BUNDLE_W]),
        .i_stall     (stall[gi]),
        .i_flush     (flush[gi]),
        .i_check     (chk_en[gi] & w_check_on),
        .i_clr       (clr),
        .o_kind      (w_kind[gi]),
        .o_err_hold  (err_hold[gi]),
        .o_err_map   (err_map[gi]),
        .o_err_flush (err_flush[gi]),
        .o_viol_cnt  (viol_cnt[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

  // Scan downwards so the lowest violating boundary is the one left standing.
  always_comb begin
    w_any      = 1'b0;
    w_idx      = '0;
    w_idx_kind = ERR_NONE;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (w_kind[i] != ERR_NONE) begin
        w_any      = 1'b1;
        w_idx      = SW'(i);
        w_idx_kind = w_kind[i];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WARM:    w_state_next = ARMED;
      ARMED:   if (!clr && w_any) w_state_next = FAULT;
      FAULT:   if (clr) w_state_next = ARMED;
      default: w_state_next = WARM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= WARM;
      r_cycle       <= '0;
      r_first_stage <= '0;
      r_first_kind  <= ERR_NONE;
      r_first_cycle <= '0;
    end else begin
      r_state <= w_state_next;
      if (clr) begin
        r_cycle       <= '0;
        r_first_stage <= '0;
        r_first_kind  <= ERR_NONE;
        r_first_cycle <= '0;
      end else begin
        if (w_check_on) r_cycle <= r_cycle + CNT_W'(1);
        if (r_state == ARMED && w_any) begin
          r_first_stage <= w_idx;
          r_first_kind  <= w_idx_kind;
          r_first_cycle <= r_cycle;
        end
      end
    end
  end

  assign fault       = (r_state == FAULT);
  assign first_stage = r_first_stage;
  assign first_kind  = r_first_kind;
  assign first_cycle = r_first_cycle;

endmodule

// File: tb/tb_pipe_stage_monitor.sv
// Randomized and directed bench for pipe_stage_monitor against a cycle-level reference model.
module tb_pipe_stage_monitor;

  localparam int NS   = 4;
  localparam int BW   = 64;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [BW-1:0] BUB = 64'h0000_0000_0000_0013;

  logic            clock = 1'b0;
  logic            reset;
  logic            clr;
  logic [NS*BW-1:0] stage_in;
  logic [NS*BW-1:0] stage_out;
  logic [NS-1:0]   stall, flush, chk_en;
  logic [NS-1:0]   err_hold, err_map, err_flush;
  logic            fault;
  logic [1:0]      first_stage;
  logic [1:0]      first_kind;
  logic [CW-1:0]   first_cycle;
  logic [NS*CW-1:0] viol_cnt;

  always #5 clock = ~clock;

  pipe_stage_monitor #(
    .NUM_STAGES (NS),
    .BUNDLE_W   (BW),
    .CNT_W      (CW),
    .BUBBLE     (BUB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .stage_in    (stage_in),
    .stage_out   (stage_out),
    .stall       (stall),
    .flush       (flush),
    .chk_en      (chk_en),
    .clr         (clr),
    .err_hold    (err_hold),
    .err_map     (err_map),
    .err_flush   (err_flush),
    .fault       (fault),
    .first_stage (first_stage),
    .first_kind  (first_kind),
    .first_cycle (first_cycle),
    .viol_cnt    (viol_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: last cycle's inputs plus the expected visible state.
  logic [BW-1:0] m_in [NS];
  logic [BW-1:0] m_out [NS];
  logic [NS-1:0] m_stall, m_flush;
  bit            m_warm;
  bit            m_fault;
  int            m_fs, m_fk, m_fc, m_cyc;
  int            m_cnt [NS];
  logic [NS-1:0] e_hold, e_map, e_flush;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_eval();
    int kind;
    int first;
    int first_k;
    logic [BW-1:0] o;
    e_hold  = '0;
    e_map   = '0;
    e_flush = '0;
    if (reset) begin
      m_warm = 1; m_fault = 0; m_fs = 0; m_fk = 0; m_fc = 0; m_cyc = 0;
      for (int k = 0; k < NS; k++) m_cnt[k] = 0;
    end else begin
      first   = -1;
      first_k = 0;
      for (int k = 0; k < NS; k++) begin
        kind = 0;
        o = stage_out[k*BW +: BW];
        if (!m_warm && chk_en[k]) begin
          if (m_flush[k])      kind = (o !== BUB)      ? 3 : 0;
          else if (m_stall[k]) kind = (o !== m_out[k]) ? 1 : 0;
          else                 kind = (o !== m_in[k])  ? 2 : 0;
        end
        if (clr) kind = 0;
        if (kind != 0) begin
          e_hold[k]  = (kind == 1);
          e_map[k]   = (kind == 2);
          e_flush[k] = (kind == 3);
          if (m_cnt[k] < CMAX) m_cnt[k]++;
          if (first < 0) begin
            first   = k;
            first_k = kind;
          end
        end
      end
      if (clr) begin
        m_fault = 0; m_fs = 0; m_fk = 0; m_fc = 0; m_cyc = 0;
        for (int k = 0; k < NS; k++) m_cnt[k] = 0;
      end else begin
        if (first >= 0 && !m_fault) begin
          m_fault = 1; m_fs = first; m_fk = first_k; m_fc = m_cyc;
        end
        if (!m_warm) m_cyc = (m_cyc + 1) % (CMAX + 1);
      end
      m_warm = 0;
    end
    for (int k = 0; k < NS; k++) begin
      m_in[k]  = stage_in[k*BW +: BW];
      m_out[k] = stage_out[k*BW +: BW];
    end
    m_stall = stall;
    m_flush = flush;
  endtask

  task automatic step();
    model_eval();
    @(posedge clock);
    #1;
    chk("err_hold", 64'(err_hold), 64'(e_hold));
    chk("err_map", 64'(err_map), 64'(e_map));
    chk("err_flush", 64'(err_flush), 64'(e_flush));
    chk("fault", 64'(fault), 64'(m_fault));
    chk("first_stage", 64'(first_stage), 64'(m_fs));
    chk("first_kind", 64'(first_kind), 64'(m_fk));
    chk("first_cycle", 64'(first_cycle), 64'(m_fc));
    for (int k = 0; k < NS; k++)
      chk($sformatf("viol_cnt%0d", k), 64'(viol_cnt[k*CW +: CW]), 64'(m_cnt[k]));
    $display("cycle: rst=%0b clr=%0b stall=%h flush=%h en=%h -> hold=%h map=%h flush=%h fault=%0b cnt=%h",
             reset, clr, stall, flush, chk_en, err_hold, err_map, err_flush, fault, viol_cnt);
  endtask

  // Drive the value each register should hold given what was applied last cycle.
  task automatic drive_good();
    for (int k = 0; k < NS; k++)
      stage_out[k*BW +: BW] = m_flush[k] ? BUB : (m_stall[k] ? m_out[k] : m_in[k]);
  endtask

  task automatic corrupt(input int k);
    stage_out[k*BW +: BW] = stage_out[k*BW +: BW] ^ 64'(($urandom | 32'd1));
  endtask

  task automatic idle();
    clr    = 1'b0;
    stall  = '0;
    flush  = '0;
    chk_en = '1;
    for (int k = 0; k < NS; k++) stage_in[k*BW +: BW] = {$urandom, $urandom};
    drive_good();
  endtask

  task automatic rnd_cycle(input int err_pct, input int clr_pct);
    for (int k = 0; k < NS; k++) stage_in[k*BW +: BW] = {$urandom, $urandom};
    stall  = NS'($urandom & $urandom);
    flush  = NS'($urandom & $urandom & $urandom);
    chk_en = ($urandom_range(0, 9) == 0) ? NS'($urandom) : '1;
    drive_good();
    for (int k = 0; k < NS; k++)
      if ($urandom_range(0, 99) < err_pct) corrupt(k);
    clr = ($urandom_range(0, 99) < clr_pct);
    step();
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; stall = '0; flush = '0; chk_en = '1;
    stage_in = '0; stage_out = '0;
    repeat (3) step();
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_cnt", 64'(viol_cnt), 64'd0);

    // Snapshot-warmup cycle: garbage on the Q side must not be flagged.
    reset = 1'b0;
    idle();
    stage_out = ~stage_out;
    step();
    chk("warm_quiet", 64'(err_hold | err_map | err_flush), 64'd0);

    idle(); stage_in[0 +: BW] = 64'h1234; step();
    idle(); step();
    chk("norm_err", 64'(err_map | err_hold | err_flush), 64'd0);
    chk("norm_fault", 64'(fault), 64'd0);

    idle(); stall[1] = 1'b1; step();
    idle(); corrupt(1); step();
    chk("hold_err", 64'(err_hold), 64'd2);
    chk("hold_fault", 64'(fault), 64'd1);
    chk("hold_stage", 64'(first_stage), 64'd1);
    chk("hold_kind", 64'(first_kind), 64'd1);

    idle(); clr = 1'b1; step();
    chk("clr_fault", 64'(fault), 64'd0);

    idle(); flush[2] = 1'b1; stall[2] = 1'b1; step();
    idle(); stage_out[2*BW +: BW] = 64'hDEAD; step();
    chk("flush_err", 64'(err_flush), 64'd4);
    chk("flush_nohold", 64'(err_hold), 64'd0);
    chk("flush_kind", 64'(first_kind), 64'd3);

    idle(); clr = 1'b1; step();
    idle(); step();
    idle(); corrupt(0); corrupt(3); step();
    chk("map2_err", 64'(err_map), 64'd9);
    chk("map2_stage", 64'(first_stage), 64'd0);
    chk("map2_cnt0", 64'(viol_cnt[0 +: CW]), 64'd1);
    chk("map2_cnt3", 64'(viol_cnt[3*CW +: CW]), 64'd1);

    repeat (20) begin
      idle(); corrupt(0); step();
    end
    chk("sat_cnt0", 64'(viol_cnt[0 +: CW]), 64'd15);

    idle(); corrupt(1); clr = 1'b1; step();
    chk("clrv_fault", 64'(fault), 64'd0);
    chk("clrv_err", 64'(err_map | err_hold | err_flush), 64'd0);
    chk("clrv_cnt", 64'(viol_cnt), 64'd0);
    idle(); step();
    chk("clrv_after", 64'(fault), 64'd0);

    repeat (400) rnd_cycle(5, 1);

    idle(); step();
    idle(); corrupt(2); step();
    chk("pre_rst_fault", 64'(fault), 64'd1);
    reset = 1'b1; idle(); step();
    chk("midrst_fault", 64'(fault), 64'd0);
    chk("midrst_cnt", 64'(viol_cnt), 64'd0);
    chk("midrst_cycle", 64'(first_cycle), 64'd0);
    reset = 1'b0;
    repeat (30) rnd_cycle(10, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
